// File: rtl/div_pkg.sv
// Shared types and constants for the iterative unsigned divider.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring compare-subtract step: subtract d from rem when it fits.
module div_step
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  always_comb begin
    q_bit    = (rem >= d);
    rem_next = q_bit ? (rem - d) : rem;
  end

endmodule

// File: rtl/div_iterate.sv
// Sequential unsigned shift-subtract divider core (one quotient bit per cycle).
// Optional div_zero output port enabled by defining DIVU_ZERO_FLAG_EN.
module div_iterate
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH,
  parameter int unsigned CNT_W = DIV_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor_aligned,
  input  logic [CNT_W-1:0] shift_cnt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
`ifdef DIVU_ZERO_FLAG_EN
  ,
  output logic             div_zero
`endif
);

  div_state_t       state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] k_q, k_d;
  logic [WIDTH-1:0] quotient_d, remainder_d;
  logic             busy_d, done_d;
  logic [WIDTH-1:0] step_rem;
  logic             step_bit;
`ifdef DIVU_ZERO_FLAG_EN
  logic             zero_d;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .d        (d_q),
    .rem_next (step_rem),
    .q_bit    (step_bit)
  );

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    d_d         = d_q;
    q_d         = q_q;
    k_d         = k_q;
    quotient_d  = quotient;
    remainder_d = remainder;
`ifdef DIVU_ZERO_FLAG_EN
    zero_d      = div_zero;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          rem_d = dividend;
          d_d   = divisor_aligned;
          k_d   = shift_cnt;
          q_d   = '0;
          if (divisor_aligned == '0) begin
            // Divide-by-zero skips iteration: all-ones quotient, dividend back.
            state_d     = DONE;
            quotient_d  = '1;
            remainder_d = dividend;
`ifdef DIVU_ZERO_FLAG_EN
            zero_d      = 1'b1;
`endif
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        rem_d = step_rem;
        q_d   = {q_q[WIDTH-2:0], step_bit};
        d_d   = d_q >> 1;
        if (k_q == '0) begin
          state_d     = DONE;
          quotient_d  = {q_q[WIDTH-2:0], step_bit};
          remainder_d = step_rem;
`ifdef DIVU_ZERO_FLAG_EN
          zero_d      = 1'b0;
`endif
        end else begin
          k_d = k_q - CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    // done trails the DONE state by one register stage.
    done_d = (state_q == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      d_q       <= '0;
      q_q       <= '0;
      k_q       <= '0;
      quotient  <= '0;
      remainder <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef DIVU_ZERO_FLAG_EN
      div_zero  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      d_q       <= d_d;
      q_q       <= q_d;
      k_q       <= k_d;
      quotient  <= quotient_d;
      remainder <= remainder_d;
      busy      <= busy_d;
      done      <= done_d;
`ifdef DIVU_ZERO_FLAG_EN
      div_zero  <= zero_d;
`endif
    end
  end

endmodule

// File: tb/tb_div_iterate.sv
// Self-checking bench for div_iterate: directed table, random ops vs arithmetic model, corner sequences.
module tb_div_iterate;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor_aligned = '0;
  logic [4:0]  shift_cnt = '0;
  logic        busy, done;
  logic [31:0] quotient, remainder;
`ifdef DIVU_ZERO_FLAG_EN
  logic        div_zero;
`endif

  int checks = 0;
  int failures = 0;

  div_iterate dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .dividend        (dividend),
    .divisor_aligned (divisor_aligned),
    .shift_cnt       (shift_cnt),
    .busy            (busy),
    .done            (done),
    .quotient        (quotient),
    .remainder       (remainder)
`ifdef DIVU_ZERO_FLAG_EN
    ,
    .div_zero        (div_zero)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] dvd;
    logic [31:0] dal;
    logic [4:0]  sc;
    logic [31:0] exp_q;
    logic [31:0] exp_r;
    int          exp_lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: true division of the un-aligned divisor, or the divide-by-zero convention.
  task automatic model(input logic [31:0] dvd, input logic [31:0] dal, input logic [4:0] sc,
                       output logic [31:0] q, output logic [31:0] r, output int lat);
    logic [31:0] dv;
    if (dal == 0) begin
      q = 32'hFFFF_FFFF; r = dvd; lat = 1;
    end else begin
      dv = dal >> sc;
      q = dvd / dv; r = dvd % dv; lat = int'(sc) + 2;
    end
  endtask

  // Launch one op, return edges-to-done (-1 on timeout) and busy after the capture edge.
  task automatic do_op(input logic [31:0] dvd, input logic [31:0] dal, input logic [4:0] sc,
                       output int lat, output logic busy0);
    @(negedge clk);
    dividend = dvd; divisor_aligned = dal; shift_cnt = sc; start = 1'b1;
    @(posedge clk); #1;
    busy0 = busy;
    start = 1'b0;
    dividend = $urandom; divisor_aligned = $urandom; shift_cnt = 5'($urandom);
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (done) begin lat = n; break; end
    end
  endtask

  task automatic run_and_check(input string tag, input logic [31:0] dvd, input logic [31:0] dal,
                               input logic [4:0] sc);
    logic [31:0] eq, er;
    int el, lat;
    logic b0;
    model(dvd, dal, sc, eq, er, el);
    do_op(dvd, dal, sc, lat, b0);
    check({tag, ".busy"}, 64'(b0), 64'(1));
    check({tag, ".latency"}, 64'(lat), 64'(el));
    check({tag, ".quotient"}, 64'(quotient), 64'(eq));
    check({tag, ".remainder"}, 64'(remainder), 64'(er));
`ifdef DIVU_ZERO_FLAG_EN
    check({tag, ".div_zero"}, 64'(div_zero), 64'(dal == 0));
`endif
    @(posedge clk); #1;
    check({tag, ".done_width"}, 64'(done), 64'(0));
    check({tag, ".idle"}, 64'(busy), 64'(0));
  endtask

  vec_t vecs[5];

  initial begin
    logic [31:0] dv, dvd;
    int s, first_done, n_done;
    logic exp_done;

    vecs[0] = '{32'd100, 32'd56, 5'd3, 32'd14, 32'd2, 5};
    vecs[1] = '{32'hFFFF_FFFF, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 32'd0, 33};
    vecs[2] = '{32'd5, 32'd0, 5'd0, 32'hFFFF_FFFF, 32'd5, 1};
    vecs[3] = '{32'd3, 32'd7, 5'd0, 32'd0, 32'd3, 2};
    vecs[4] = '{32'd1000, 32'd768, 5'd8, 32'd333, 32'd1, 10};

    repeat (3) @(posedge clk);
    #1;
    check("reset.busy", 64'(busy), 64'(0));
    check("reset.done", 64'(done), 64'(0));
    check("reset.quotient", 64'(quotient), 64'(0));
    check("reset.remainder", 64'(remainder), 64'(0));
`ifdef DIVU_ZERO_FLAG_EN
    check("reset.div_zero", 64'(div_zero), 64'(0));
`endif
    @(negedge clk); rst = 1'b0;

    // Directed table with hand-computed expectations.
    for (int i = 0; i < 5; i++) begin
      int lat;
      logic b0;
      do_op(vecs[i].dvd, vecs[i].dal, vecs[i].sc, lat, b0);
      check($sformatf("vec%0d.latency", i), 64'(lat), 64'(vecs[i].exp_lat));
      check($sformatf("vec%0d.quotient", i), 64'(quotient), 64'(vecs[i].exp_q));
      check($sformatf("vec%0d.remainder", i), 64'(remainder), 64'(vecs[i].exp_r));
`ifdef DIVU_ZERO_FLAG_EN
      check($sformatf("vec%0d.div_zero", i), 64'(div_zero), 64'(vecs[i].dal == 0));
`endif
      @(posedge clk); #1;
      check($sformatf("vec%0d.done_width", i), 64'(done), 64'(0));
    end

    // Random aligned operands: shift as far left as fits under the dividend.
    for (int i = 0; i < 40; i++) begin
      dv  = $urandom >> $urandom_range(0, 31);
      dvd = $urandom >> $urandom_range(0, 31);
      if (i % 10 == 9) dv = 0;
      else if (dv == 0) dv = 1;
      s = 0;
      if (dv != 0)
        while (s < 31 && ((64'(dv) << (s + 1)) <= 64'(dvd))) s++;
      run_and_check($sformatf("rnd%0d", i), dvd, dv << s, 5'(s));
    end

    // start during RUN and during the DONE->IDLE transition is ignored.
    @(negedge clk);
    dividend = 32'd100; divisor_aligned = 32'd56; shift_cnt = 5'd3; start = 1'b1;
    first_done = -1; n_done = 0;
    for (int e = 0; e <= 20; e++) begin
      @(posedge clk); #1;
      if (done) begin n_done++; if (first_done < 0) first_done = e; end
      start = (e == 1 || e == 4);
      if (start) begin dividend = 32'd1000; divisor_aligned = 32'd768; shift_cnt = 5'd8; end
    end
    start = 1'b0;
    check("ignore.done_count", 64'(n_done), 64'(1));
    check("ignore.done_edge", 64'(first_done), 64'(5));
    check("ignore.quotient", 64'(quotient), 64'(14));
    check("ignore.remainder", 64'(remainder), 64'(2));

    // start held high: one operation every shift_cnt+3 cycles.
    @(negedge clk);
    dividend = 32'd3; divisor_aligned = 32'd7; shift_cnt = 5'd0; start = 1'b1;
    for (int e = 0; e <= 8; e++) begin
      @(posedge clk); #1;
      exp_done = (e == 2 || e == 5 || e == 8);
      check($sformatf("b2b.done_e%0d", e), 64'(done), 64'(exp_done));
    end
    @(negedge clk); start = 1'b0;
    repeat (3) @(posedge clk);

    // Reset mid-RUN aborts with no stale done.
    @(negedge clk);
    dividend = 32'hFFFF_FFFF; divisor_aligned = 32'h8000_0000; shift_cnt = 5'd31; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    #2; rst = 1'b1; #1;
    check("rst.busy", 64'(busy), 64'(0));
    check("rst.done", 64'(done), 64'(0));
    check("rst.quotient", 64'(quotient), 64'(0));
    check("rst.remainder", 64'(remainder), 64'(0));
    @(negedge clk); rst = 1'b0;
    n_done = 0;
    for (int e = 0; e < 40; e++) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    check("rst.stale_done", 64'(n_done), 64'(0));
    run_and_check("rst.fresh", 32'd100, 32'd56, 5'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
